// File: rtl/upsample.sv
// rtl/upsample.sv - 2x2 pixel-replicating upsampler, raster in / raster out
// Optional data_out_last output enabled by defining UPSAMPLE_LAST_EN.
module upsample #(
   parameter int DATA_WIDTH = 16,
   parameter int IN_COLS    = 16,
   parameter int IN_ROWS    = 16
) (
   input  logic                  CLK,
   input  logic                  RESETN,
   input  logic                  data_in_valid,
   input  logic [DATA_WIDTH-1:0] data_in_data,
   output logic                  data_in_ready,
   output logic                  data_out_valid,
   output logic [DATA_WIDTH-1:0] data_out_data,
`ifdef UPSAMPLE_LAST_EN
   output logic                  data_out_last,
`endif
   input  logic                  data_out_ready
);

   localparam int OXW = $clog2(2 * IN_COLS);
   localparam int OYW = $clog2(2 * IN_ROWS);
   localparam int LBW = OXW - 1;
   localparam logic [OXW-1:0] OX_LAST = OXW'(2 * IN_COLS - 1);
   localparam logic [OYW-1:0] OY_LAST = OYW'(2 * IN_ROWS - 1);

   typedef enum logic {
      LIVE   = 1'b0,
      REPLAY = 1'b1
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [OXW-1:0]        ox;
   logic [OXW-1:0]        ox_nxt;
   logic [OYW-1:0]        oy;
   logic [OYW-1:0]        oy_nxt;
   logic [DATA_WIDTH-1:0] line_buf [IN_COLS];
   logic [LBW-1:0]        lb_idx;
   logic                  out_xfer;
   logic                  in_xfer;
   logic                  row_end;

   assign lb_idx   = ox[OXW-1:1];
   assign row_end  = (ox == OX_LAST);
   assign out_xfer = data_out_valid & data_out_ready;
   assign in_xfer  = data_in_valid & data_in_ready;

   // LIVE forwards the source combinationally and only pops it on the odd copy;
   // REPLAY re-emits the row captured in the line buffer.
   always_comb begin
      data_out_valid = 1'b0;
      data_out_data  = data_in_data;
      data_in_ready  = 1'b0;
      case (state)
         LIVE: begin
            data_out_valid = data_in_valid;
            data_out_data  = data_in_data;
            data_in_ready  = data_out_ready & ox[0];
         end
         REPLAY: begin
            data_out_valid = 1'b1;
            data_out_data  = line_buf[lb_idx];
            data_in_ready  = 1'b0;
         end
         default: ;
      endcase
      if (!RESETN) begin
         data_out_valid = 1'b0;
         data_in_ready  = 1'b0;
      end
   end

   always_comb begin
      state_nxt = state;
      ox_nxt    = ox;
      oy_nxt    = oy;
      if (out_xfer) begin
         if (row_end) begin
            ox_nxt    = '0;
            oy_nxt    = (oy == OY_LAST) ? '0 : oy + OYW'(1);
            state_nxt = (state == LIVE) ? REPLAY : LIVE;
         end else begin
            ox_nxt = ox + OXW'(1);
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RESETN) begin
         state <= LIVE;
         ox    <= '0;
         oy    <= '0;
      end else begin
         state <= state_nxt;
         ox    <= ox_nxt;
         oy    <= oy_nxt;
      end
   end

   // Writes are gated by data_in_ready, which is already forced low in reset.
   always_ff @(posedge CLK) begin
      if (in_xfer) begin
         line_buf[lb_idx] <= data_in_data;
      end
   end

`ifdef UPSAMPLE_LAST_EN
   assign data_out_last = data_out_valid & row_end & (oy == OY_LAST);
`endif

endmodule

// File: doc/upsample.md
UPSAMPLE -- requirements
Module: upsample

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16: pixel width in bits.
REQ-002 SHALL have parameter IN_COLS, default 16: input pixels per row, power of two, ≥2.
REQ-003 SHALL have parameter IN_ROWS, default 16: input rows per frame, power of two, ≥1.
REQ-004 SHALL have port CLK, input, 1: single clock, all state updates on rising edge.
REQ-005 SHALL have port RESETN, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port data_in_valid, input, 1: input pixel valid.
REQ-007 SHALL have port data_in_data, input, DATA_WIDTH: input pixel, raster order.
REQ-008 SHALL have port data_in_ready, output, 1: upsample accepts input pixel.
REQ-009 SHALL have port data_out_valid, output, 1: output pixel valid.
REQ-010 SHALL have port data_out_data, output, DATA_WIDTH: output pixel, raster order, 2*IN_COLS by 2*IN_ROWS frame.
REQ-011 SHALL have port data_out_ready, input, 1: sink accepts output pixel.

Function
REQ-012 SHALL perform 2x2 pixel replication: input pixel (r,c) appears at output (2r,2c), (2r,2c+1), (2r+1,2c), (2r+1,2c+1).
REQ-013 SHALL keep output column counter ox (0..2*IN_COLS-1) and output row counter oy (0..2*IN_ROWS-1), both clog2-width, wrapping to 0.
REQ-014 SHALL use two states: LIVE (oy even) and REPLAY (oy odd).
REQ-015 SHALL transfer an output pixel only when data_out_valid & data_out_ready are both high; an input pixel only when data_in_valid & data_in_ready are both high.
REQ-016 In LIVE: data_out_valid = data_in_valid; data_out_data = data_in_data; data_in_ready = data_out_ready & ox[0]; zero-cycle combinational path.
REQ-017 In LIVE, the input pixel SHALL be consumed only on its second (odd-ox) output copy; the source holds it across both copies per valid/ready rules.
REQ-018 In LIVE, on each input transfer, the pixel SHALL be written to line buffer entry ox>>1.
REQ-019 Line buffer: IN_COLS x DATA_WIDTH, asynchronous read, no reset.
REQ-020 In REPLAY: data_out_valid = 1; data_out_data = line buffer[ox>>1]; data_in_ready = 0.
REQ-021 On each output transfer, ox SHALL increment; at ox = 2*IN_COLS-1, ox wraps to 0 and oy increments (wrapping at 2*IN_ROWS-1 to 0).
REQ-022 The LIVE→REPLAY transition SHALL occur after the output transfer at ox=2*IN_COLS-1; REPLAY→LIVE likewise.
REQ-023 With no output transfer, ox, oy, state and line buffer SHALL hold.
REQ-024 Back-to-back operation SHALL sustain one output pixel per cycle under continuous valid/ready, with no bubbles at row or frame boundaries.

Reset
REQ-025 While RESETN is low at a rising edge, ox=0, oy=0, state=LIVE.
REQ-026 While RESETN is low, data_out_valid=0 and data_in_ready=0, combinationally forced.
REQ-027 Reset mid-row or mid-REPLAY SHALL abandon the partial frame; the next accepted input is pixel (0,0).

Configuration
REQ-028 With UPSAMPLE_LAST_EN defined, SHALL add output port data_out_last, 1 bit: high with data_out_valid when ox=2*IN_COLS-1 and oy=2*IN_ROWS-1; 0 during reset.
REQ-029 Without UPSAMPLE_LAST_EN, port data_out_last SHALL be absent; all other behaviour identical.

Verification
REQ-030 Ramp input 0..255 (16x16), ready always 1 -> 1024 outputs; row 0 = 0,0,1,1,…,15,15; row 1 identical; row 2 starts 16,16; exactly 256 input transfers.
REQ-031 data_out_ready toggling 1010… on ramp -> same 1024-pixel sequence; no input accepted on even-ox cycles.
REQ-032 data_in_valid low for 5 cycles at input pixel 7, row 0 -> data_out_valid low for those cycles, ox stays 14; REPLAY row unaffected by input.
REQ-033 RESETN low for 1 cycle at ox=9, oy=1 -> data_out_valid=0 that cycle; next output is input pixel 0 at (0,0).
REQ-034 Two consecutive frames, ready=1 -> 2048 cycles of continuous data_out_valid after first input; with UPSAMPLE_LAST_EN, data_out_last high exactly on cycles 1024 and 2048.
